// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver state encoding and frame-bit levels.
// The transmitter uses the same frame-bit constants.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver line/host bundle. master = receiver side, slave = line/host side.
interface uart_receiver_if #(
  parameter int WIDTH = 8
);
  logic             i_baud_tick;
  logic             i_rx_serial;
  logic [WIDTH-1:0] o_rx_data;
  logic             o_rx_valid;
  logic             o_parity_err;
  logic             o_frame_err;
  logic             o_busy;

  modport master (
    input  i_baud_tick, i_rx_serial,
    output o_rx_data, o_rx_valid, o_parity_err, o_frame_err, o_busy
  );

  modport slave (
    output i_baud_tick, i_rx_serial,
    input  o_rx_data, o_rx_valid, o_parity_err, o_frame_err, o_busy
  );
endinterface

// File: rtl/uart_receiver_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Reset value is a parameter so an idle-high line does not look like a start bit.
module uart_receiver_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  // Two-stage capture of the raw line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start(0), WIDTH data bits LSB first, optional parity, stop(1).
// Bits are sampled mid-bit using OVERSAMPLE baud_tick enables per bit period.
//
//  state  | meaning
//  IDLE   | waiting for a falling edge on the synchronized line
//  START  | counting half a bit to re-check the start bit (glitch reject)
//  DATA   | sampling WIDTH data bits, one per full bit period
//  PARITY | sampling parity bit and computing the mismatch flag
//  STOP   | sampling stop bit, publishing word and flags
//  BREAK  | stop bit was low; wait for line high before re-arming
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  uart_receiver_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  logic             w_rxs;
  state_t           r_state;
  logic [TW-1:0]    r_tick_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_perr;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_parity_err;
  logic             r_frame_err;

  uart_receiver_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.i_rx_serial),
    .o_q (w_rxs)
  );

  // Frame FSM with counters, shift register and registered host outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rxs == START_BIT) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (bus.i_baud_tick) begin
            if (r_tick_cnt == TICK_MID) begin
              r_tick_cnt <= '0;
              if (w_rxs == START_BIT) begin
                r_state   <= ST_DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (bus.i_baud_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rxs, r_shift[WIDTH-1:1]};
              r_bit_cnt  <= r_bit_cnt + BW'(1);
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bus.i_baud_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              r_perr     <= (^{r_shift, w_rxs}) ^ PARITY_ODD;
              r_state    <= ST_STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (bus.i_baud_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt   <= '0;
              r_rx_data    <= r_shift;
              r_parity_err <= PARITY_EN ? r_perr : 1'b0;
              r_frame_err  <= (w_rxs != STOP_BIT);
              r_rx_valid   <= 1'b1;
              r_state      <= (w_rxs == STOP_BIT) ? ST_IDLE : ST_BREAK;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        ST_BREAK: begin
          // Line held low: no new start detection until it returns high
          if (w_rxs == STOP_BIT) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_rx_data    = r_rx_data;
  assign bus.o_rx_valid   = r_rx_valid;
  assign bus.o_parity_err = r_parity_err;
  assign bus.o_frame_err  = r_frame_err;
  assign bus.o_busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table of frames, hand sequences for glitch, break,
// reset and back-to-back cases, and randomized frames against a frame-level model.
module tb_uart_receiver;
  localparam int BITCLK = 64; // 16 ticks per bit, one tick every 4 clocks

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  frame_t got_q[$];
  frame_t exp_q[$];
  logic prev_valid;

  uart_receiver_if #(.WIDTH(8)) bus_if ();

  uart_receiver #(
    .WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: one clock high every 4 clocks
  initial begin
    int div;
    div = 0;
    bus_if.i_baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      bus_if.i_baud_tick = (div == 3);
    end
  end

  // Capture every rx_valid pulse and check it lasts a single clock
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    if (bus_if.o_rx_valid) begin
      frame_t f;
      f.data = bus_if.o_rx_data;
      f.perr = bus_if.o_parity_err;
      f.ferr = bus_if.o_frame_err;
      got_q.push_back(f);
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_width actual=2+ clocks required=1 clock");
      end
    end
    prev_valid = bus_if.o_rx_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, parity bit (stop bit left to the caller)
  task automatic drive_head(input logic [7:0] d, input logic pbit);
    bus_if.i_rx_serial = 1'b0;
    wait_clks(BITCLK);
    for (int i = 0; i < 8; i++) begin
      bus_if.i_rx_serial = d[i];
      wait_clks(BITCLK);
    end
    bus_if.i_rx_serial = pbit;
    wait_clks(BITCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit);
    drive_head(d, pbit);
    bus_if.i_rx_serial = 1'b1;
    wait_clks(BITCLK);
  endtask

  task automatic check_frames(input string name, input int n);
    chk({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      frame_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({name, "_data"}, g.data, e.data);
      chk({name, "_perr"}, g.perr, e.perr);
      chk({name, "_ferr"}, g.ferr, e.ferr);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic void expect_frame(input logic [7:0] d, input logic p, input logic f);
    frame_t e;
    e.data = d; e.perr = p; e.ferr = f;
    exp_q.push_back(e);
  endfunction

  // Frame-level model: even parity means ones(data)+parity must be even
  function automatic logic model_perr(input logic [7:0] d, input logic pbit);
    int ones;
    ones = pbit;
    for (int i = 0; i < 8; i++) ones += d[i];
    return (ones % 2) != 0;
  endfunction

  vec_t vecs[6];

  initial begin
    checks = 0;
    errors = 0;
    bus_if.i_rx_serial = 1'b1;
    rst = 1'b0;
    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h12, 1'b1, 8'h12, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 1'b0, 8'h7F, 1'b1, 1'b0};
    vecs[5] = '{8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0};

    wait_clks(5);
    chk("rst_data",  bus_if.o_rx_data, 8'h00);
    chk("rst_valid", bus_if.o_rx_valid, 1'b0);
    chk("rst_perr",  bus_if.o_parity_err, 1'b0);
    chk("rst_ferr",  bus_if.o_frame_err, 1'b0);
    chk("rst_busy",  bus_if.o_busy, 1'b0);
    rst = 1'b1;
    wait_clks(10);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].pbit);
      expect_frame(vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
      wait_clks(20);
      check_frames($sformatf("vec%0d", v), 1);
    end

    // Short glitch: low for 3 ticks, then 0x12
    bus_if.i_rx_serial = 1'b0;
    wait_clks(12);
    chk("glitch_busy_hi", bus_if.o_busy, 1'b1);
    bus_if.i_rx_serial = 1'b1;
    wait_clks(BITCLK);
    chk("glitch_busy_lo", bus_if.o_busy, 1'b0);
    chk("glitch_data_held", bus_if.o_rx_data, 8'hC3);
    check_frames("glitch", 0);
    send_frame(8'h12, 1'b0);
    expect_frame(8'h12, 1'b0, 1'b0);
    wait_clks(10);
    check_frames("after_glitch", 1);

    // Stop bit low, line held low two bit times, then 0x01
    drive_head(8'h55, 1'b0);
    bus_if.i_rx_serial = 1'b0;
    wait_clks(BITCLK + 40);
    chk("break_busy", bus_if.o_busy, 1'b1);
    chk("break_ferr", bus_if.o_frame_err, 1'b1);
    wait_clks(BITCLK - 40);
    bus_if.i_rx_serial = 1'b1;
    wait_clks(8);
    chk("break_release_busy", bus_if.o_busy, 1'b0);
    chk("break_ferr_held", bus_if.o_frame_err, 1'b1);
    expect_frame(8'h55, 1'b0, 1'b1);
    check_frames("break", 1);
    send_frame(8'h01, 1'b1);
    expect_frame(8'h01, 1'b0, 1'b0);
    wait_clks(10);
    check_frames("after_break", 1);

    // Reset during the 4th data bit of 0xFF
    bus_if.i_rx_serial = 1'b0;
    wait_clks(BITCLK);
    for (int i = 0; i < 3; i++) begin
      bus_if.i_rx_serial = 1'b1;
      wait_clks(BITCLK);
    end
    wait_clks(30);
    chk("pre_rst_busy", bus_if.o_busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_data",  bus_if.o_rx_data, 8'h00);
    chk("midrst_valid", bus_if.o_rx_valid, 1'b0);
    chk("midrst_ferr",  bus_if.o_frame_err, 1'b0);
    chk("midrst_busy",  bus_if.o_busy, 1'b0);
    wait_clks(3);
    rst = 1'b1;
    wait_clks(8 * BITCLK);
    check_frames("midrst", 0);
    send_frame(8'h81, 1'b0);
    expect_frame(8'h81, 1'b0, 1'b0);
    wait_clks(10);
    check_frames("after_rst", 1);

    // Back-to-back with no idle gap
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    wait_clks(10);
    check_frames("b2b", 2);

    // Randomized frames against the model
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       pbit;
      logic       bad_stop;
      int         gap;
      d        = 8'($urandom);
      pbit     = (^d) ^ ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 5) == 0);
      gap      = $urandom_range(0, 40);
      expect_frame(d, model_perr(d, pbit), bad_stop);
      if (bad_stop) begin
        drive_head(d, pbit);
        bus_if.i_rx_serial = 1'b0;
        wait_clks(BITCLK + $urandom_range(0, 64));
        bus_if.i_rx_serial = 1'b1;
        wait_clks(4 + gap);
      end else begin
        send_frame(d, pbit);
        wait_clks(gap);
      end
    end
    wait_clks(10);
    check_frames("rand", 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
